cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter: LINE_WORDS, 4, 32-bit words per cache line (16-byte line); only 4 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 rc_miss_in  in  1  cache reports a miss; sampled only in IDLE.
REQ-005 rc_addr_in  in  32  miss address; line base = rc_addr_in & ~32'hF.
REQ-006 rc_dirty_in  in  1  victim line dirty; write it back before the fill.
REQ-007 rc_wbaddr_in  in  32  victim line address; bits [3:0] ignored.
REQ-008 rc_wbdata_in  in  128  victim line data; word k is bits [32k+31:32k].
REQ-009 rc_ldata_out  out  128  assembled refill line, same word packing as rc_wbdata_in.
REQ-010 rc_load_en_out  out  1  one-cycle strobe: rc_ldata_out is valid; cache writes the line.
REQ-011 rc_begin_load_out  out  1  high in FILL and LOAD; drives the cache begin_load input.
REQ-012 rc_busy_out  out  1  high in any state other than IDLE.
REQ-013 mem_req_out  out  1  memory beat request.
REQ-014 mem_we_out  out  1  1 = write beat (WB), 0 = read beat (FILL).
REQ-015 mem_addr_out  out  32  beat address = line base + 4*beat.
REQ-016 mem_wdata_out  out  32  write beat data = latched victim word[beat].
REQ-017 mem_ack_in  in  1  memory completes the current beat on this rising edge.
REQ-018 mem_rdata_in  in  32  read data, valid in the cycle mem_ack_in=1 during FILL.

Function
REQ-019 FSM states: IDLE, WB, FILL, LOAD; 2-bit beat counter.
REQ-020 IDLE, rc_miss_in=1: latch miss base, victim base, rc_wbdata_in and rc_dirty_in; clear line buffer to 0; beat=0; next state WB if dirty, else FILL.
REQ-021 rc_miss_in while not IDLE is ignored; latched request fields do not change until the next IDLE capture.
REQ-022 mem_req_out=1 on every WB/FILL cycle, including wait cycles, and 0 in IDLE/LOAD.
REQ-023 mem_we_out=1 in WB and 0 otherwise; mem_wdata_out=0 outside WB.
REQ-024 mem_addr_out equals victim base+4*beat in WB, miss base+4*beat in FILL, and 0 otherwise.
REQ-025 Beat completes on an edge with mem_ack_in=1 and mem_req_out=1; the counter increments and the address updates the following cycle.
REQ-026 mem_ack_in=0 holds the beat: address, data and counter are unchanged (unbounded wait states allowed).
REQ-027 FILL beat k ack: line buffer word k <= mem_rdata_in; other words unchanged.
REQ-028 Completion of beat 3 in WB goes to FILL with beat=0; completion of beat 3 in FILL goes to LOAD; the counter wraps 3->0.
REQ-029 LOAD lasts exactly one cycle with rc_load_en_out=1, then returns to IDLE.
REQ-030 rc_ldata_out is always the line buffer and is held after LOAD until the next capture.
REQ-031 mem_ack_in in IDLE/LOAD is ignored.
REQ-032 Zero-wait latency: a clean miss sampled at edge t gives FILL for cycles t+1..t+4, LOAD at t+5 and IDLE at t+6.
REQ-033 Zero-wait latency: a dirty miss gives WB for t+1..t+4, FILL for t+5..t+8 and LOAD at t+9.
REQ-034 A miss asserted in the LOAD cycle is not accepted; it is sampled in IDLE on the following cycle.

Reset
REQ-035 rst=1 at an edge: state IDLE, beat 0, line buffer 0, latched fields 0.
REQ-036 After reset, all outputs are 0.
REQ-037 Reset in any state, including mid-beat with mem_req_out=1, aborts the transfer.
REQ-038 After an aborted transfer, mem_req_out=0 from the cycle after the reset edge and no load strobe is produced.
REQ-039 rst has priority over rc_miss_in and mem_ack_in.

Verification
REQ-040 Clean miss, rc_addr_in=32'hFFF11114, ack every cycle, rdata 0,0x12345678,0,0 -> addrs FFF11110/14/18/1C with we=0; load_en 1 at t+5; ldata=128'h00000000_00000000_12345678_00000000.
REQ-041 Dirty miss, wbaddr=32'hFFF22200, wbdata word2=0x87654321 -> four writes FFF22200..0C; third write data 0x87654321; then four reads; load_en at t+9.
REQ-042 Wait states: ack withheld for 3 cycles on FILL beat 1 -> mem_addr_out stays base+4 and mem_req_out stays 1; load_en delayed by 3 cycles.
REQ-043 rc_miss_in held high through a transfer -> exactly one fill per IDLE visit; new capture in the cycle after LOAD's return to IDLE.
REQ-044 rst pulsed during WB beat 2 -> next cycle all outputs 0, state IDLE; a following clean miss completes normally.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller.
// On a miss, optionally writes the dirty victim line back to memory, then
// reads the missing line one 32-bit beat at a time and hands the assembled
// line to the cache with a one-cycle load strobe.
module cache_refill_ctrl #(
  parameter int LINE_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rc_miss_in,
  input  logic [31:0]              rc_addr_in,
  input  logic                     rc_dirty_in,
  input  logic [31:0]              rc_wbaddr_in,
  input  logic [LINE_WORDS*32-1:0] rc_wbdata_in,
  output logic [LINE_WORDS*32-1:0] rc_ldata_out,
  output logic                     rc_load_en_out,
  output logic                     rc_begin_load_out,
  output logic                     rc_busy_out,
  output logic                     mem_req_out,
  output logic                     mem_we_out,
  output logic [31:0]              mem_addr_out,
  output logic [31:0]              mem_wdata_out,
  input  logic                     mem_ack_in,
  input  logic [31:0]              mem_rdata_in
);

  localparam int          LINE_BITS = LINE_WORDS * 32;
  localparam logic [1:0]  LAST_BEAT = 2'(LINE_WORDS - 1);
  localparam logic [31:0] LINE_MASK = ~32'hF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2,
    S_LOAD = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [31:0]          miss_base_q, miss_base_d;
  logic [31:0]          wb_base_q, wb_base_d;
  logic [LINE_BITS-1:0] wb_data_q, wb_data_d;
  logic [LINE_BITS-1:0] line_q, line_d;

  logic capture;
  logic beat_done;

  // A request is only taken from IDLE; a beat ends when memory acks an active request.
  // The victim's dirty bit is not kept as a register: it is consumed by the
  // IDLE->WB/FILL decision and the WB state itself remembers it.
  assign capture   = (state_q == S_IDLE) && rc_miss_in;
  assign beat_done = ((state_q == S_WB) || (state_q == S_FILL)) && mem_ack_in;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering in simulation.
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: walk WB (if dirty) -> FILL -> LOAD -> IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE: if (rc_miss_in) state_d = rc_dirty_in ? S_WB : S_FILL;
      S_WB:   if (beat_done && (beat_q == LAST_BEAT)) state_d = S_FILL;
      S_FILL: if (beat_done && (beat_q == LAST_BEAT)) state_d = S_LOAD;
      S_LOAD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: memory beat interface and cache handshake, all decoded from registered state.
  always_comb begin
    mem_req_out       = 1'b0;
    mem_we_out        = 1'b0;
    mem_addr_out      = '0;
    mem_wdata_out     = '0;
    rc_load_en_out    = 1'b0;
    rc_begin_load_out = 1'b0;
    rc_busy_out       = (state_q != S_IDLE);
    case (state_q)
      S_WB: begin
        mem_req_out   = 1'b1;
        mem_we_out    = 1'b1;
        mem_addr_out  = wb_base_q | {28'h0, beat_q, 2'b00};
        mem_wdata_out = wb_data_q[{beat_q, 5'b0} +: 32];
      end
      S_FILL: begin
        mem_req_out       = 1'b1;
        mem_addr_out      = miss_base_q | {28'h0, beat_q, 2'b00};
        rc_begin_load_out = 1'b1;
      end
      S_LOAD: begin
        rc_load_en_out    = 1'b1;
        rc_begin_load_out = 1'b1;
      end
      default: ;
    endcase
  end

  assign rc_ldata_out = line_q;

  // Datapath next-state: capture the request in IDLE, advance the beat and collect read words.
  always_comb begin
    beat_d      = beat_q;
    miss_base_d = miss_base_q;
    wb_base_d   = wb_base_q;
    wb_data_d   = wb_data_q;
    line_d      = line_q;
    if (capture) begin
      miss_base_d = rc_addr_in & LINE_MASK;
      wb_base_d   = rc_wbaddr_in & LINE_MASK;
      wb_data_d   = rc_wbdata_in;
      line_d      = '0;
      beat_d      = 2'd0;
    end else if (beat_done) begin
      beat_d = beat_q + 2'd1;
      if (state_q == S_FILL) begin
        line_d[{beat_q, 5'b0} +: 32] = mem_rdata_in;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q      <= 2'd0;
      miss_base_q <= '0;
      wb_base_q   <= '0;
      wb_data_q   <= '0;
      // NOTE: the line buffer is reset despite its width because it drives
      // rc_ldata_out directly and must read as zero after reset.
      line_q      <= '0;
    end else begin
      beat_q      <= beat_d;
      miss_base_q <= miss_base_d;
      wb_base_q   <= wb_base_d;
      wb_data_q   <= wb_data_d;
      line_q      <= line_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus pushes the expected memory
// beats and load lines, a monitor pops and compares them as the DUT emits them.
module tb_cache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         rc_miss_in;
  logic [31:0]  rc_addr_in;
  logic         rc_dirty_in;
  logic [31:0]  rc_wbaddr_in;
  logic [127:0] rc_wbdata_in;
  logic [127:0] rc_ldata_out;
  logic         rc_load_en_out;
  logic         rc_begin_load_out;
  logic         rc_busy_out;
  logic         mem_req_out;
  logic         mem_we_out;
  logic [31:0]  mem_addr_out;
  logic [31:0]  mem_wdata_out;
  logic         mem_ack_in;
  logic [31:0]  mem_rdata_in;

  cache_refill_ctrl #(.LINE_WORDS(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .rc_miss_in        (rc_miss_in),
    .rc_addr_in        (rc_addr_in),
    .rc_dirty_in       (rc_dirty_in),
    .rc_wbaddr_in      (rc_wbaddr_in),
    .rc_wbdata_in      (rc_wbdata_in),
    .rc_ldata_out      (rc_ldata_out),
    .rc_load_en_out    (rc_load_en_out),
    .rc_begin_load_out (rc_begin_load_out),
    .rc_busy_out       (rc_busy_out),
    .mem_req_out       (mem_req_out),
    .mem_we_out        (mem_we_out),
    .mem_addr_out      (mem_addr_out),
    .mem_wdata_out     (mem_wdata_out),
    .mem_ack_in        (mem_ack_in),
    .mem_rdata_in      (mem_rdata_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_load;
    bit           we;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] line;
  } exp_t;

  exp_t        exp_q[$];
  int          compares   = 0;
  int          mismatches = 0;
  int          cyc        = 0;
  int          t_cap      = 0;
  int          load_cnt   = 0;
  int          last_load_edge = 0;
  logic [31:0] stall_addr = '0;
  int          stall_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compares++;
    if (act !== exp) begin
      mismatches++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_beat(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.is_load = 1'b0; e.we = we; e.addr = addr; e.wdata = wdata; e.line = '0;
    exp_q.push_back(e);
  endtask

  // Four read beats from base, then the load of the hand-computed line.
  task automatic push_fill(input logic [31:0] base, input logic [127:0] line);
    exp_t e;
    for (int i = 0; i < 4; i++) push_beat(1'b0, base + 32'(4 * i), 32'h0);
    e.is_load = 1'b1; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.line = line;
    exp_q.push_back(e);
  endtask

  // Memory model: FFF1111x holds 0,12345678,0,0; elsewhere data = addr ^ 5A5A5A5A.
  function automatic logic [31:0] rd_model(input logic [31:0] addr);
    if (addr[31:4] == 28'hFFF1111) return (addr == 32'hFFF11114) ? 32'h12345678 : 32'h0;
    return addr ^ 32'h5A5A5A5A;
  endfunction

  // Memory responder: acks every cycle (also in IDLE/LOAD, which must be ignored)
  // except while a programmed stall on one read address is counting down.
  initial begin
    mem_ack_in   = 1'b0;
    mem_rdata_in = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (mem_req_out && !mem_we_out && mem_addr_out == stall_addr && stall_left > 0) begin
        mem_ack_in = 1'b0;
        stall_left--;
      end else begin
        mem_ack_in = 1'b1;
      end
      mem_rdata_in = (mem_req_out && !mem_we_out) ? rd_model(mem_addr_out) : 32'hDEADBEEF;
    end
  end

  // Monitor: compares each completed beat and each load strobe against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_out && mem_ack_in) begin
        if (exp_q.size() == 0) begin
          compares++; mismatches++;
          $display("FAIL unexpected_beat: addr %h we %b with nothing expected", mem_addr_out, mem_we_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.is_load) begin
            compares++; mismatches++;
            $display("FAIL beat_order: got beat at %h, expected load strobe", mem_addr_out);
          end else begin
            check("beat_we", mem_we_out, e.we);
            check("beat_addr", mem_addr_out, e.addr);
            check("beat_wdata", mem_wdata_out, e.wdata);
          end
        end
      end
      if (rc_load_en_out) begin
        load_cnt++;
        last_load_edge = cyc + 1;
        if (exp_q.size() == 0) begin
          compares++; mismatches++;
          $display("FAIL unexpected_load: line %h with nothing expected", rc_ldata_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (!e.is_load) begin
            compares++; mismatches++;
            $display("FAIL load_order: got load strobe, expected beat at %h", e.addr);
          end else begin
            check("load_ldata", rc_ldata_out, e.line);
            check("load_begin", rc_begin_load_out, 1'b1);
          end
        end
      end
      if (!rc_busy_out)
        check("idle_outputs", {mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
                               rc_load_en_out, rc_begin_load_out}, '0);
    end
  end

  // Called at posedge+1 with the DUT in IDLE; the next edge captures the miss.
  task automatic issue(input logic [31:0] addr, input logic dirty, input logic [31:0] wbaddr,
                       input logic [127:0] wbdata, input logic hold);
    rc_miss_in   = 1'b1;
    rc_addr_in   = addr;
    rc_dirty_in  = dirty;
    rc_wbaddr_in = wbaddr;
    rc_wbdata_in = wbdata;
    @(posedge clk); #1;
    t_cap      = cyc;
    rc_miss_in = hold;
  endtask

  // Bounded wait for the next load strobe; latency is counted in edges from the capture edge.
  task automatic wait_load(input int n_before, input int exp_lat, input string name);
    int k;
    k = 0;
    while (load_cnt <= n_before && k < 40) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (load_cnt <= n_before) begin
      compares++; mismatches++;
      $display("FAIL %s_timeout: no load strobe within 40 cycles, got %0d loads", name, load_cnt);
    end else begin
      check({name, "_latency"}, 128'(last_load_edge - t_cap), 128'(exp_lat));
    end
  endtask

  localparam logic [127:0] LINE_T1 = 128'h00000000_00000000_12345678_00000000;

  initial begin
    int n;
    rst = 1'b1; rc_miss_in = 1'b0; rc_addr_in = '0; rc_dirty_in = 1'b0;
    rc_wbaddr_in = '0; rc_wbdata_in = '0;

    // Reset state: every output zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {rc_busy_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
                            rc_load_en_out, rc_begin_load_out}, '0);
    check("reset_ldata", rc_ldata_out, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Clean miss: reads FFF11110..1C, load at capture+5.
    push_fill(32'hFFF11110, LINE_T1);
    n = load_cnt;
    issue(32'hFFF11114, 1'b0, 32'h0, '0, 1'b0);
    @(negedge clk);
    check("fill_flags", {rc_busy_out, rc_begin_load_out, mem_req_out, mem_we_out}, 4'b1110);
    wait_load(n, 5, "clean");

    // Dirty miss: write-back FFF22200..0C, then reads from 1230; request inputs
    // are scrambled after capture and must not disturb the transfer.
    push_beat(1'b1, 32'hFFF22200, 32'h11111111);
    push_beat(1'b1, 32'hFFF22204, 32'h22222222);
    push_beat(1'b1, 32'hFFF22208, 32'h87654321);
    push_beat(1'b1, 32'hFFF2220C, 32'h44444444);
    push_fill(32'h00001230, 128'h5A5A4866_5A5A4862_5A5A486E_5A5A486A);
    n = load_cnt;
    issue(32'h00001238, 1'b1, 32'hFFF22207,
          128'h44444444_87654321_22222222_11111111, 1'b0);
    rc_addr_in = 32'hBAD00000; rc_wbaddr_in = 32'hBAD11110; rc_wbdata_in = '1; rc_dirty_in = 1'b0;
    @(negedge clk);
    check("wb_flags", {rc_busy_out, rc_begin_load_out, mem_req_out, mem_we_out}, 4'b1011);
    wait_load(n, 9, "dirty");

    // Wait states: FILL beat 1 held for 3 cycles, address and request stay put.
    stall_addr = 32'h00002004;
    stall_left = 3;
    push_fill(32'h00002000, 128'h5A5A7A56_5A5A7A52_5A5A7A5E_5A5A7A5A);
    n = load_cnt;
    issue(32'h00002000, 1'b0, 32'h0, '0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_addr", mem_addr_out, 32'h00002004);
      check("stall_req", mem_req_out, 1'b1);
    end
    wait_load(n, 8, "stall");

    // Miss held high: exactly one fill per IDLE visit, recapture right after LOAD.
    push_fill(32'h00003000, 128'h5A5A6A56_5A5A6A52_5A5A6A5E_5A5A6A5A);
    push_fill(32'h00003000, 128'h5A5A6A56_5A5A6A52_5A5A6A5E_5A5A6A5A);
    n = load_cnt;
    issue(32'h00003000, 1'b0, 32'h0, '0, 1'b1);
    wait_load(n, 5, "held1");
    t_cap = last_load_edge + 1;
    wait_load(n + 1, 5, "held2");
    rc_miss_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("held_no_third", rc_busy_out, 1'b0);

    // Reset during WB beat 2: only beats 0 and 1 complete, then everything clears.
    push_beat(1'b1, 32'h00004000, 32'hAAAA0000);
    push_beat(1'b1, 32'h00004004, 32'hAAAA0001);
    @(posedge clk); #1;
    n = load_cnt;
    issue(32'h00005000, 1'b1, 32'h00004000,
          128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", {rc_busy_out, mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out,
                            rc_load_en_out, rc_begin_load_out}, '0);
    check("abort_ldata", rc_ldata_out, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_quiet", {mem_req_out, rc_load_en_out}, 2'b00);
    end
    check("abort_no_load", load_cnt, n);

    // Clean miss after the abort completes normally.
    push_fill(32'hFFF11110, LINE_T1);
    @(posedge clk); #1;
    n = load_cnt;
    issue(32'hFFF11114, 1'b0, 32'h0, '0, 1'b0);
    wait_load(n, 5, "post_abort");

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("load_count", load_cnt, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared", compares);
    $fatal(1, "watchdog");
  end

endmodule
